uart_transmitter: RTL and testbench

//   Serialises one DATA_WIDTH-bit word per request onto the UART line: start bit, data LSB first,

---
 rtl/uart_transmitter.sv | 127 ++++++++++++
 tb/tb_uart_transmitter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Bit timing is OVERSAMPLE baud ticks per bit, shared with the oversampling receiver.
`timescale 1ns/1ps
module uart_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [TCW-1:0] TICK_ONE  = TCW'(1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q;
    logic [TCW-1:0]        tick_cnt_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  bit_end;
    logic [DATA_WIDTH-1:0] shift_d;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] word);
        return (^word) ^ (PARITY_ODD != 0);
    endfunction

    // A bit period closes on the tick that finds the counter at its last value.
    assign bit_end = tick && (tick_cnt_q == TICK_LAST);
    assign shift_d = shift_q >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && tick) begin
                tick_cnt_q <= bit_end ? '0 : tick_cnt_q + TICK_ONE;
            end
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (tx_start) begin
                        shift_q    <= data_in;
                        par_q      <= parity_of(data_in);
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + BIT_ONE;
                        if (bit_cnt_q == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= par_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            tx_q <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four parameterisations driven from one tick source and
// compared against a bit-level frame model indexed by baud ticks counted since accept.
`timescale 1ns/1ps
module tb_uart_transmitter;
    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [3:0]  start_v;
    logic [15:0] data_in;
    logic [3:0]  tx_v, busy_v, done_v;

    int tests = 0;
    int fails = 0;
    int tick_div = 1;

    int cfg_dw[4] = '{8, 8, 8, 5};
    int cfg_os[4] = '{16, 16, 16, 4};
    int cfg_pe[4] = '{0, 1, 1, 1};
    int cfg_po[4] = '{0, 0, 1, 1};

    uart_transmitter #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_v[0]), .data_in(data_in[7:0]),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_transmitter #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_v[1]), .data_in(data_in[7:0]),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_transmitter #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_v[2]), .data_in(data_in[7:0]),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
    uart_transmitter #(.DATA_WIDTH(5), .OVERSAMPLE(4), .PARITY_EN(1), .PARITY_ODD(1)) u3 (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_v[3]), .data_in(data_in[4:0]),
        .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    initial forever #5 clk = ~clk;

    // Tick changes shortly after each rising edge so it is stable at the next one.
    initial begin
        int cnt;
        cnt  = 0;
        tick = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            cnt = cnt + 1;
            if (cnt >= tick_div) cnt = 0;
            tick = (cnt == 0);
        end
    end

    // Observation record of the most recent frame.
    logic obs_bits[32];
    logic obs_mid[32];
    int   obs_first[32];
    int   obs_unstable, obs_done_at, obs_done_T, obs_ndone, obs_busy_low;
    logic obs_busy_done, obs_tx_done;

    function automatic int frame_len(input int which);
        return cfg_dw[which] + 2 + cfg_pe[which];
    endfunction

    // Line levels of a whole frame, bit 0 first.
    function automatic logic [31:0] model_frame(input int which, input logic [15:0] word);
        logic [31:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < cfg_dw[which]; i++) begin
            f[i+1] = word[i];
            ones += int'(word[i]);
        end
        if (cfg_pe[which] != 0) f[cfg_dw[which]+1] = logic'((ones % 2) ^ cfg_po[which]);
        return f;
    endfunction

    function automatic int frame_errs(input int which, input logic [15:0] word);
        logic [31:0] f;
        int n;
        f = model_frame(which, word);
        n = 0;
        for (int b = 0; b < frame_len(which); b++) if (obs_bits[b] !== f[b]) n++;
        return n;
    endfunction

    function automatic logic [15:0] decoded(input int which);
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < cfg_dw[which]; i++) w[i] = obs_mid[i+1];
        return w;
    endfunction

    function automatic int dur_errs(input int which, input int per);
        int n, nb;
        n  = 0;
        nb = frame_len(which);
        for (int b = 1; b < nb - 1; b++) if (obs_first[b+1] - obs_first[b] != per) n++;
        if (obs_done_at - obs_first[nb-1] != per) n++;
        return n;
    endfunction

    function automatic logic [15:0] rand_word(input int which);
        logic [15:0] w;
        w = 16'($urandom);
        return w & ((16'd1 << cfg_dw[which]) - 16'd1);
    endfunction

    // Present a word on one DUT for a single edge; returns just after that accept edge.
    task automatic accept(input int which, input logic [15:0] word);
        @(negedge clk);
        data_in = word;
        start_v[which] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[which] = 1'b0;
    endtask

    // Watch a frame from the cycle after accept, bucketing line samples by ticks seen.
    task automatic observe(input int which, input int max_cyc, input int extra);
        int T, nb, os, cyc, b;
        logic tnext;
        bit seen[32];
        bit mseen[32];
        nb = frame_len(which);
        os = cfg_os[which];
        for (int i = 0; i < 32; i++) begin
            seen[i] = 0; mseen[i] = 0; obs_bits[i] = 1'bx; obs_mid[i] = 1'bx; obs_first[i] = -1;
        end
        obs_unstable = 0; obs_done_at = -1; obs_done_T = -1; obs_ndone = 0; obs_busy_low = 0;
        obs_busy_done = 1'bx; obs_tx_done = 1'bx;
        T = 0;
        cyc = 0;
        forever begin
            b = T / os;
            if (b < nb) begin
                if (!seen[b]) begin
                    seen[b] = 1; obs_bits[b] = tx_v[which]; obs_first[b] = cyc;
                end else if (tx_v[which] !== obs_bits[b]) begin
                    obs_unstable++;
                end
                if (!mseen[b] && T == b * os + os / 2) begin
                    mseen[b] = 1; obs_mid[b] = tx_v[which];
                end
            end
            if (done_v[which] === 1'b1) begin
                obs_ndone++;
                if (obs_done_at < 0) begin
                    obs_done_at = cyc; obs_done_T = T;
                    obs_busy_done = busy_v[which]; obs_tx_done = tx_v[which];
                end
            end else if (obs_done_at < 0 && busy_v[which] !== 1'b1) begin
                obs_busy_low++;
            end
            if (obs_done_at >= 0 && cyc - obs_done_at >= extra) break;
            if (cyc >= max_cyc) break;
            tnext = tick;
            @(negedge clk);
            cyc++;
            if (tnext) T++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({tx_v, busy_v, done_v} !== {4'hF, 4'h0, 4'h0}) begin
            fails++;
            $display("FAIL reset_state: tx/busy/done=%h required %h", {tx_v, busy_v, done_v}, 12'hF00);
        end
        rst = 1'b0;
    endtask

    task automatic test_default_a5();
        tick_div = 1;
        accept(0, 16'h00A5);
        observe(0, 400, 40);
        tests++;
        if (frame_errs(0, 16'h00A5) != 0 || obs_unstable != 0) begin
            fails++;
            $display("FAIL a5_frame: bad bits=%0d unstable=%0d required 0/0", frame_errs(0, 16'h00A5), obs_unstable);
        end
        tests++;
        if (obs_done_at + 1 != 161) begin
            fails++;
            $display("FAIL a5_latency: %0d clks required 161", obs_done_at + 1);
        end
        tests++;
        if (dur_errs(0, 16) != 0 || obs_first[1] != 16) begin
            fails++;
            $display("FAIL a5_bit_period: bad periods=%0d start len=%0d required 0/16", dur_errs(0, 16), obs_first[1]);
        end
        tests++;
        if (obs_ndone != 1 || obs_busy_low != 0 || obs_busy_done !== 1'b0 || obs_tx_done !== 1'b1) begin
            fails++;
            $display("FAIL a5_handshake: dones=%0d busy_low=%0d busy@done=%b tx@done=%b required 1/0/0/1",
                     obs_ndone, obs_busy_low, obs_busy_done, obs_tx_done);
        end
        tests++;
        if (decoded(0) !== 16'h00A5) begin
            fails++;
            $display("FAIL a5_receive: %h required 00a5", decoded(0));
        end
    endtask

    task automatic test_slow_tick();
        tick_div = 4;
        accept(0, 16'h003C);
        observe(0, 1200, 80);
        tests++;
        if (frame_errs(0, 16'h003C) != 0 || decoded(0) !== 16'h003C || obs_unstable != 0) begin
            fails++;
            $display("FAIL slow_frame: bad bits=%0d word=%h unstable=%0d required 0/003c/0",
                     frame_errs(0, 16'h003C), decoded(0), obs_unstable);
        end
        tests++;
        if (dur_errs(0, 64) != 0 || obs_first[1] < 61 || obs_first[1] > 64 || obs_ndone != 1) begin
            fails++;
            $display("FAIL slow_period: bad periods=%0d start len=%0d dones=%0d required 0/61..64/1",
                     dur_errs(0, 64), obs_first[1], obs_ndone);
        end
        tick_div = 1;
    endtask

    task automatic test_parity();
        tick_div = 1;
        for (int k = 1; k <= 2; k++) begin
            accept(k, 16'h0007);
            observe(k, 400, 20);
            tests++;
            if (obs_bits[9] !== logic'(k == 1) || frame_errs(k, 16'h0007) != 0 || obs_done_T != 176) begin
                fails++;
                $display("FAIL parity_%0s: parity bit=%b bad bits=%0d frame ticks=%0d required %b/0/176",
                         (k == 1) ? "even" : "odd", obs_bits[9], frame_errs(k, 16'h0007), obs_done_T, logic'(k == 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        tick_div = 1;
        a = rand_word(0);
        b = rand_word(0) ^ 16'h0081;
        @(negedge clk);
        data_in = a;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fork
            observe(0, 400, 0);
            begin
                repeat (100) begin
                    @(posedge clk);
                    #3 data_in = 16'($urandom);
                end
            end
        join
        tests++;
        if (frame_errs(0, a) != 0 || decoded(0) !== a || obs_done_at != 160) begin
            fails++;
            $display("FAIL b2b_first: word=%h done at %0d required %h/160", decoded(0), obs_done_at, a);
        end
        data_in = b;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        tests++;
        if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_gap: tx=%b busy=%b right after done, required 0/1", tx_v[0], busy_v[0]);
        end
        observe(0, 400, 20);
        tests++;
        if (frame_errs(0, b) != 0 || decoded(0) !== b || obs_ndone != 1) begin
            fails++;
            $display("FAIL b2b_second: word=%h dones=%0d required %h/1", decoded(0), obs_ndone, b);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        int ndone;
        tick_div = 1;
        accept(0, 16'h00FF);
        repeat (70) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: tx/busy/done=%b%b%b required 100", tx_v[0], busy_v[0], done_v[0]);
        end
        ndone = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_v[0] === 1'b1 || tx_v[0] !== 1'b1) ndone++;
        end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d cycles with done or low line, required 0", ndone);
        end
        w = rand_word(0);
        accept(0, w);
        observe(0, 400, 10);
        tests++;
        if (frame_errs(0, w) != 0 || decoded(0) !== w || obs_ndone != 1) begin
            fails++;
            $display("FAIL abort_resend: word=%h dones=%0d required %h/1", decoded(0), obs_ndone, w);
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] w;
        tick_div = 2;
        w = rand_word(0);
        accept(0, w);
        fork
            observe(0, 800, 60);
            begin
                repeat (5) begin
                    repeat (10) @(posedge clk);
                    #3;
                    data_in = 16'($urandom);
                    start_v[0] = 1'b1;
                    @(posedge clk);
                    #3 start_v[0] = 1'b0;
                end
            end
        join
        tests++;
        if (frame_errs(0, w) != 0 || obs_ndone != 1 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start: bad bits=%0d dones=%0d tx=%b busy=%b required 0/1/1/0",
                     frame_errs(0, w), obs_ndone, tx_v[0], busy_v[0]);
        end
        tick_div = 1;
    endtask

    task automatic test_random();
        int which, nb;
        logic [15:0] w;
        for (int n = 0; n < 12; n++) begin
            which    = $urandom_range(0, 3);
            tick_div = $urandom_range(1, 3);
            w        = rand_word(which);
            nb       = frame_len(which);
            accept(which, w);
            observe(which, nb * cfg_os[which] * 3 + 50, 2);
            tests++;
            if (frame_errs(which, w) != 0 || obs_unstable != 0 || obs_done_T != nb * cfg_os[which] || obs_ndone != 1) begin
                fails++;
                $display("FAIL random_%0d dut%0d word %h: bad bits=%0d unstable=%0d ticks=%0d dones=%0d required 0/0/%0d/1",
                         n, which, w, frame_errs(which, w), obs_unstable, obs_done_T, obs_ndone, nb * cfg_os[which]);
            end
        end
        tick_div = 1;
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        data_in = '0;
        test_reset();
        test_default_a5();
        test_slow_tick();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_ignore_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
